// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: forward-select codes and hazard FSM encoding.
package riscv_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'b00,
    HZ_LOAD_STALL = 2'b01,
    HZ_MDU_WAIT   = 2'b10
  } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// Operand forward-select comparator: MEM result wins over WB, x0 never forwards.
module fwd_select
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel
);

  // Priority compare; a load in MEM has no data yet, so it cannot forward from MEM
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller: operand forwarding, load-use bubbles, MDU stalls, branch flushes
// and stall/flush performance counters.
module hazard_control_unit
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_is_mdu,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic             wb_reg_write,
  input  logic             mdu_done,
  output logic [1:0]       forward_sel_a,
  output logic [1:0]       forward_sel_b,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned BCNT_W = 2;

  hz_state_e         state, state_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              flush_evt;
  logic              load_use;
  logic [1:0]        sel_a_raw, sel_b_raw;

  fwd_select u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a_raw)
  );

  fwd_select u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b_raw)
  );

  // Forward selects are forced to the register file while in reset
  assign forward_sel_a = rst_n ? sel_a_raw : FWD_REG;
  assign forward_sel_b = rst_n ? sel_b_raw : FWD_REG;

  // Load in EX whose destination is read by the instruction in ID
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Next-state and Mealy stall/flush decode
  always_comb begin
    state_nxt     = state;
    bcnt_nxt      = bcnt;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start     = 1'b0;
    flush_evt     = 1'b0;
    unique case (state)
      HZ_RUN: begin
        if (ex_is_mdu) begin
          mdu_start = 1'b1;
          state_nxt = HZ_MDU_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (LOAD_USE_BUBBLES > 1) begin
            bcnt_nxt  = BCNT_W'(LOAD_USE_BUBBLES - 1);
            state_nxt = HZ_LOAD_STALL;
          end
        end
      end
      HZ_LOAD_STALL: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        bcnt_nxt    = bcnt - BCNT_W'(1);
        if (bcnt <= BCNT_W'(1)) begin
          state_nxt = HZ_RUN;
        end
      end
      HZ_MDU_WAIT: begin
        if (mdu_done) begin
          state_nxt = HZ_RUN;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end
      end
      default: begin
        state_nxt = HZ_RUN;
        bcnt_nxt  = '0;
      end
    endcase
    if (!rst_n) begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_ex_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      mdu_start     = 1'b0;
      flush_evt     = 1'b0;
    end
  end

  // State, bubble counter and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HZ_RUN;
      bcnt         <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      if (pc_stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_evt) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule
